truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential truth-table harness for small combinational gate networks of the guide exercises (NAND/NOR expression modules). It drives every input combination (minterm 0 to 2^N-1, counted in order) onto the expression under test and waits a programmable settle time. It then samples the expression's output and assembles the full truth-table vector. At the end it compares that vector against an expected vector and reports the result with a done pulse.

## Interface
Parameters:
- N, default 2: number of expression inputs; truth table has 2^N rows.
- SETTLE, default 1: extra cycles each minterm is held before sampling; 0 is legal.

Ports:
- clk  input  1  single clock. All state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a sweep. Sampled only in IDLE.
- expected  input  2^N  reference truth table; bit m = required output for minterm m. Latched on the accepted start.
- x_out  output  N  drives the expression inputs. Equals the current minterm index, MSB = first variable. For N=2: x_out[1]=a, x_out[0]=b.
- s_in  input  1  expression output fed back.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2^N  captured truth table; bit m = s_in sampled for minterm m.
- match  output  1  table_out == latched expected. Valid from the done cycle until the next accepted start.

## Operation
- Reset (rst_n=0 at a clock edge): state IDLE. x_out=0, busy=0, done=0, table_out=0, match=0, settle counter=0, latched expected=0.
- States:
  - IDLE: outputs are held.
  - APPLY: the current minterm is on x_out. A settle counter runs from 0 to SETTLE.
- IDLE → APPLY on an edge with start=1. At that edge:
  - expected is latched.
  - table_out ← 0, match ← 0, x_out ← 0, busy ← 1, counter ← 0.
- In APPLY, at each edge:
  - If counter < SETTLE: counter increments.
  - If counter == SETTLE: s_in is written into table_out[x_out] and counter ← 0.
    - If x_out < 2^N-1: x_out increments.
    - Otherwise (last minterm): done ← 1, busy ← 0, match ← (final table == latched expected, including the bit just sampled), x_out ← 0, state ← IDLE.
- done deasserts on the following edge.
- start while busy is ignored and does not restart or queue a sweep.
- start asserted in the same cycle done is high is accepted, because the state is IDLE. The new sweep clears table_out and match at that edge.
- table_out and match hold their values in IDLE until the next accepted start.
- rst_n=0 mid-sweep aborts at that edge to the full reset values; no done pulse is issued.
- x_out wraps only through the return to IDLE, never by counter overflow. The minterm counter is N bits and the settle counter is at least clog2(SETTLE+1) bits wide.

## Timing
- Let E0 be the edge that accepts start.
- Minterm m is on x_out during cycles E0+(SETTLE+1)·m .. E0+(SETTLE+1)·(m+1)-1.
- s_in for minterm m is sampled at edge E0+(SETTLE+1)·(m+1).
- done is high for exactly one cycle, after edge E0+(SETTLE+1)·2^N. busy falls at that same edge.
- For N=2, SETTLE=1: 8 cycles from the accept edge to done.
- s_in must be stable SETTLE+1 cycles after x_out changes. The block adds no input synchronizer.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then start=0 for 10 cycles → x_out=0, busy=0, done=0, table_out=4'h0, match=0 throughout.
- Correct NAND expression, N=2, SETTLE=1: s_in = nand(nand(a,a), b), expected=4'hD, start for 1 cycle →
  - x_out steps 0,1,2,3 with 2 cycles each;
  - done after edge 8, table_out=4'b1101, match=1, busy=0.
- Faulty expression: s_in = nand(a,b) with expected=4'hD → table_out=4'b0111, match=0, done still after edge 8.
- Ignored start: pulse start again at cycle 3 of a sweep → no restart, done once after edge 8.
- Back-to-back sweeps: start held high continuously → a new sweep is accepted in the done cycle. table_out reads 0 on the next cycle, and a second done follows 8 cycles later.
- Reset mid-sweep, plus SETTLE=0:
  - rst_n=0 at cycle 5 → next cycle busy=0, table_out=0, no done.
  - Then a SETTLE=0 instance with s_in=x_out[0] → done after edge 4, table_out=4'b1010.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// ============================================================================
// Module      : truth_table_sweeper_if
// Description : Bundle of the sweep handshake and expression-drive signals
//               shared between the truth_table_sweeper and its user.
//   start      - request a sweep (sampled only while idle)
//   expected   - reference truth table, bit m = required output of minterm m
//   x_out      - minterm currently driven onto the expression inputs
//   s_in       - expression output fed back
//   busy       - sweep in progress
//   done       - one-cycle completion pulse
//   table_out  - captured truth table
//   match      - table_out equals the latched expected vector
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface truth_table_sweeper_if #(
  parameter int N = 2
);
  logic                  start;
  logic [(1 << N) - 1:0] expected;
  logic [N-1:0]          x_out;
  logic                  s_in;
  logic                  busy;
  logic                  done;
  logic [(1 << N) - 1:0] table_out;
  logic                  match;

  // Master: the harness user / expression side.
  modport master (
    output start, expected, s_in,
    input  x_out, busy, done, table_out, match
  );

  // Slave: the sweeper itself.
  modport slave (
    input  start, expected, s_in,
    output x_out, busy, done, table_out, match
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks every minterm 0..2^N-1 onto x_out, holds each one for
//               SETTLE extra cycles, samples s_in into the truth table and
//               finally compares the table against the latched expected
//               vector, flagging completion with a one-cycle done pulse.
// Ports       : clk   - single clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - truth_table_sweeper_if slave modport
// Parameters  : N      - number of expression inputs (2^N table rows)
//               SETTLE - extra hold cycles per minterm before sampling
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  truth_table_sweeper_if.slave  bus
);

  localparam int             ROWS   = 1 << N;
  // A zero SETTLE still needs a one-bit counter so the compare stays legal.
  localparam int             CW     = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  C_SETTLE = CW'(SETTLE);
  localparam logic [N-1:0]   C_LAST   = {N{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_x;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [ROWS-1:0] r_tbl;
  logic            r_match;
  logic [ROWS-1:0] r_expected;

  // Table including the bit sampled this cycle, so the final compare sees
  // the last minterm without an extra cycle of latency.
  logic [ROWS-1:0] w_tbl_next;

  always_comb begin
    w_tbl_next        = r_tbl;
    w_tbl_next[r_x]   = bus.s_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tbl      <= '0;
      r_match    <= 1'b0;
      r_expected <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_expected <= bus.expected;
            r_tbl      <= '0;
            r_match    <= 1'b0;
            r_x        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (r_cnt != C_SETTLE) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            r_tbl <= w_tbl_next;
            if (r_x != C_LAST) begin
              r_x <= r_x + N'(1);
            end else begin
              // Last minterm: wrap x_out here rather than by overflow.
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_match <= (w_tbl_next == r_expected);
              r_x     <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x_out     = r_x;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.table_out = r_tbl;
  assign bus.match     = r_match;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper. Instance A uses
//               SETTLE=1, instance B uses SETTLE=0, both with N=2. Expected
//               tables come from evaluating the expression at every minterm.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         tests = 0;
  int         fails = 0;

  logic       start_a, start_b;
  logic [3:0] exp_a, exp_b;
  logic [3:0] f_a, f_b;
  int         mode_a, mode_b;

  truth_table_sweeper_if #(.N(2)) if_a ();
  truth_table_sweeper_if #(.N(2)) if_b ();

  // Expression under test: 0 = nand(nand(a,a),b), 1 = nand(a,b),
  // 2 = b, otherwise an arbitrary function given by lookup vector f.
  function automatic logic expr(input int mode, input logic [1:0] x, input logic [3:0] f);
    logic a, b;
    a = x[1];
    b = x[0];
    case (mode)
      0:       return ~(~(a & a) & b);
      1:       return ~(a & b);
      2:       return b;
      default: return f[x];
    endcase
  endfunction

  function automatic logic [3:0] model_table(input int mode, input logic [3:0] f);
    logic [3:0] t;
    t = '0;
    for (int m = 0; m < 4; m++) t[m] = expr(mode, 2'(m), f);
    return t;
  endfunction

  assign if_a.start    = start_a;
  assign if_a.expected = exp_a;
  assign if_a.s_in     = expr(mode_a, if_a.x_out, f_a);
  assign if_b.start    = start_b;
  assign if_b.expected = exp_b;
  assign if_b.s_in     = expr(mode_b, if_b.x_out, f_b);

  truth_table_sweeper #(.N(2), .SETTLE(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  truth_table_sweeper #(.N(2), .SETTLE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic samp(input int w, output logic [1:0] x, output logic b, output logic d,
                      output logic m, output logic [3:0] t);
    if (w == 0) begin
      x = if_a.x_out; b = if_a.busy; d = if_a.done; m = if_a.match; t = if_a.table_out;
    end else begin
      x = if_b.x_out; b = if_b.busy; d = if_b.done; m = if_b.match; t = if_b.table_out;
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v;
    else        start_b = v;
  endtask

  // Runs from cycle 0 after the accept edge to the cycle after done.
  task automatic body(input int w, input logic [3:0] ev, input int mode, input logic [3:0] f,
                      input int ign_at, input logic hold);
    int         s;
    int         cycles;
    logic [3:0] ref_t;
    logic [1:0] x;
    logic       b, d, m;
    logic [3:0] t;
    s      = (w == 0) ? 1 : 0;
    cycles = 4 * (s + 1);
    ref_t  = model_table(mode, f);
    for (int k = 0; k < cycles; k++) begin
      samp(w, x, b, d, m, t);
      check("busy_high", 32'(b), 32'd1);
      check("done_low", 32'(d), 32'd0);
      check("x_out_step", 32'(x), 32'(k / (s + 1)));
      if (k == 0) begin
        check("table_cleared", 32'(t), 32'd0);
        check("match_cleared", 32'(m), 32'd0);
      end
      set_start(w, hold || (k == ign_at));
      @(negedge clk);
    end
    samp(w, x, b, d, m, t);
    check("done_pulse", 32'(d), 32'd1);
    check("busy_fall", 32'(b), 32'd0);
    check("x_out_wrap", 32'(x), 32'd0);
    check("table_final", 32'(t), 32'(ref_t));
    check("match_final", 32'(m), 32'(ref_t == ev));
    if (!hold) begin
      @(negedge clk);
      samp(w, x, b, d, m, t);
      check("done_deassert", 32'(d), 32'd0);
      check("table_hold", 32'(t), 32'(ref_t));
      check("match_hold", 32'(m), 32'(ref_t == ev));
    end
  endtask

  task automatic sweep(input int w, input logic [3:0] ev, input int mode, input logic [3:0] f,
                       input int ign_at, input logic hold);
    if (w == 0) begin exp_a = ev; mode_a = mode; f_a = f; end
    else        begin exp_b = ev; mode_b = mode; f_b = f; end
    set_start(w, 1'b1);
    @(negedge clk);
    body(w, ev, mode, f, ign_at, hold);
  endtask

  initial begin
    logic [3:0] rf, re;
    int         w;
    rst_n   = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    exp_a   = '0;   exp_b   = '0;
    f_a     = '0;   f_b     = '0;
    mode_a  = 0;    mode_b  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset values must hold across an idle stretch.
    for (int k = 0; k < 10; k++) begin
      check("rst_x_out", 32'(if_a.x_out), 32'd0);
      check("rst_busy", 32'(if_a.busy), 32'd0);
      check("rst_done", 32'(if_a.done), 32'd0);
      check("rst_table", 32'(if_a.table_out), 32'd0);
      check("rst_match", 32'(if_a.match), 32'd0);
      @(negedge clk);
    end
    check("rst_b_busy", 32'(if_b.busy), 32'd0);
    check("rst_b_table", 32'(if_b.table_out), 32'd0);

    // Correct NAND network.
    sweep(0, 4'hD, 0, 4'h0, -1, 1'b0);
    check("nand_ok_table", 32'(if_a.table_out), 32'hD);
    check("nand_ok_match", 32'(if_a.match), 32'd1);

    // Faulty network.
    sweep(0, 4'hD, 1, 4'h0, -1, 1'b0);
    check("nand_bad_table", 32'(if_a.table_out), 32'h7);
    check("nand_bad_match", 32'(if_a.match), 32'd0);

    // Start during a sweep is ignored.
    sweep(0, 4'hD, 0, 4'h0, 3, 1'b0);

    // Back-to-back: start held through the done cycle.
    sweep(0, 4'hD, 0, 4'h0, -1, 1'b1);
    @(negedge clk);
    body(0, 4'hD, 0, 4'h0, -1, 1'b0);

    // Reset in the middle of a sweep.
    exp_a   = 4'hD;
    mode_a  = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(if_a.busy), 32'd0);
    check("abort_table", 32'(if_a.table_out), 32'd0);
    check("abort_done", 32'(if_a.done), 32'd0);
    check("abort_x_out", 32'(if_a.x_out), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(if_a.done), 32'd0);
    end

    // Zero settle time: done after four edges.
    sweep(1, 4'hA, 2, 4'h0, -1, 1'b0);
    check("settle0_table", 32'(if_b.table_out), 32'hA);
    check("settle0_match", 32'(if_b.match), 32'd1);

    // Random functions and expected vectors on both instances.
    for (int i = 0; i < 12; i++) begin
      w  = i % 2;
      rf = 4'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rf : 4'($urandom);
      sweep(w, re, 3, rf, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
